fpu_op_sequencer: RTL and testbench
===================================

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 Parameter LATENCY, default 8, FPU cycles waited between start pulse release and result capture; legal range 1..255.
REQ-002 clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 in_valid  in  1  operand pair present.
REQ-005 in_ready  out  1  sequencer can accept an operand pair.
REQ-006 in_op_a, in_op_b  in  32 each  operands; format: sign bit 31, exponent 30:25 (bias 31), mantissa 24:0.
REQ-007 fpu_op_A, fpu_op_B  out  32 each  operands driven to the FPU.
REQ-008 fpu_reset  out  1  active-low FPU start/reset pulse.
REQ-009 fpu_data  in  32  FPU data_out.
REQ-010 fpu_status  in  4  FPU status_out.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_data, out_status  out  32 / 4  captured result and status.
REQ-014 sticky_status  out  4  OR of all captured statuses since last clear.
REQ-015 clear_sticky  in  1  synchronous clear of sticky_status.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 op_count  out  8  count of completed output handshakes.

Function
REQ-018 States: IDLE, START, WAIT, HOLD; encoded as one registered state variable.
REQ-019 IDLE: in_ready=1; on in_valid=1, register in_op_a/in_op_b into fpu_op_A/fpu_op_B, go START.
REQ-020 START (exactly 1 cycle): fpu_reset=0; load wait counter with LATENCY-1; go WAIT.
REQ-021 WAIT: fpu_reset=1; counter decrements each cycle; when counter=0, capture fpu_data->out_data and fpu_status->out_status, go HOLD.
REQ-022 out_valid SHALL rise exactly LATENCY+1 rising edges after the input-accept edge.
REQ-023 HOLD: out_valid=1, out_data/out_status stable; on out_ready=1, go IDLE, op_count+1.
REQ-024 out_ready low: remain in HOLD indefinitely; no data change.
REQ-025 fpu_op_A/fpu_op_B SHALL remain stable from the accept edge until the HOLD exit edge; in IDLE they keep their last value.
REQ-026 in_valid outside IDLE is ignored (in_ready=0); no operand buffering; max throughput one op per LATENCY+3 cycles.
REQ-027 sticky_status |= fpu_status on the capture edge; clear_sticky=1 zeroes it; clear and capture on the same edge -> sticky_status = captured fpu_status.
REQ-028 op_count wraps 255->0.
REQ-029 fpu_reset=1 in IDLE, WAIT, HOLD; 0 only in START and while reset is asserted.

Reset
REQ-030 reset=0 at a rising edge: state=IDLE, out_valid=0, out_data=0, out_status=0, sticky_status=0, op_count=0, counter=0, fpu_op_A=fpu_op_B=0, fpu_reset=0; in_ready=0 and busy=0 while reset=0.
REQ-031 Reset mid-operation (START/WAIT/HOLD) discards the in-flight result; no capture, no op_count increment; in_ready=1 on the first cycle after reset deasserts.

Verification (FPU instance attached, LATENCY=8)
REQ-032 A=0x3E000000, B=0x3E000000 (1.0+1.0) -> out_valid 9 edges after accept, out_data=0x40000000, fpu_reset low exactly 1 cycle.
REQ-033 A=0x3F000000, B=0x3C000000 (1.5+0.5) -> out_data=0x40000000; A=0x40000000, B=0x40000000 -> 0x42000000; op_count increments by 1 per result.
REQ-034 A=0x3E000000, B=0xBE000000 (1.0+(-1.0)) with out_ready held 0 for 20 cycles -> out_valid stays 1, out_data=0x00000000 stable, in_valid pulses ignored, fpu_op_A/B unchanged.
REQ-035 Two ops with differing fpu_status, then clear_sticky coincident with a third capture -> sticky_status equals OR of the first two, then exactly the third status.
REQ-036 Reset asserted in WAIT cycle 4 -> all outputs zero per REQ-030, op_count unchanged at 0, next op completes normally with correct data.
REQ-037 256 completed ops -> op_count returns to 0.

Source files
------------

// File: rtl/fpu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer_if
// Operand-in / result-out handshake bundle for the FPU operation sequencer.
//   in_valid / in_ready     : operand pair handshake (producer -> sequencer)
//   in_op_a / in_op_b       : 32-bit operands
//   out_valid / out_ready   : result handshake (sequencer -> consumer)
//   out_data / out_status   : captured FPU result and status flags
// Modports:
//   slave  : the sequencer side (accepts operands, offers results)
//   master : the environment side (offers operands, accepts results)
// ---------------------------------------------------------------------------
interface fpu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_status;

    modport slave (
        input  in_valid, in_op_a, in_op_b, out_ready,
        output in_ready, out_valid, out_data, out_status
    );

    modport master (
        output in_valid, in_op_a, in_op_b, out_ready,
        input  in_ready, out_valid, out_data, out_status
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer
// Drives one operation at a time through a fixed-latency FPU: latches an
// operand pair, pulses the FPU start/reset low for one cycle, waits LATENCY
// cycles, captures the FPU result/status and holds it until the consumer
// accepts it.
// Ports:
//   clock, reset      : system clock, synchronous active-low reset
//   bus (slave)       : operand-in / result-out handshakes
//   fpu_op_A/B        : operands presented to the FPU (stable for the op)
//   fpu_reset         : active-low FPU start pulse
//   fpu_data/status   : FPU result inputs, sampled on the capture edge
//   sticky_status     : OR of captured statuses since the last clear
//   clear_sticky      : synchronous clear of sticky_status
//   busy              : sequencer is not idle
//   op_count          : completed result handshakes, wraps at 8 bits
// ---------------------------------------------------------------------------
module fpu_op_sequencer #(
    parameter int LATENCY = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    fpu_op_sequencer_if.slave    bus,
    output logic [31:0]          fpu_op_A,
    output logic [31:0]          fpu_op_B,
    output logic                 fpu_reset,
    input  logic [31:0]          fpu_data,
    input  logic [3:0]           fpu_status,
    output logic [3:0]           sticky_status,
    input  logic                 clear_sticky,
    output logic                 busy,
    output logic [7:0]           op_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Counter preload so that capture lands LATENCY cycles after the start pulse.
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  cnt_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic [31:0] out_data_r;
    logic [3:0]  out_status_r;
    logic [3:0]  sticky_r;
    logic [7:0]  op_count_r;
    logic        accept_s;
    logic        capture_s;
    logic        release_s;

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    next_state_s = ST_START;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_r == 8'd0) begin
                    next_state_s = ST_HOLD;
                    capture_s    = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    next_state_s = ST_IDLE;
                    release_s    = 1'b1;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, wait counter, operand/result registers, sticky flags and op counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            out_data_r   <= 32'd0;
            out_status_r <= 4'd0;
            sticky_r     <= 4'd0;
            op_count_r   <= 8'd0;
        end else begin
            state_r <= next_state_s;

            if (accept_s) begin
                op_a_r <= bus.in_op_a;
                op_b_r <= bus.in_op_b;
            end

            if (state_r == ST_START) begin
                cnt_r <= LAT_M1;
            end else if ((state_r == ST_WAIT) && (cnt_r != 8'd0)) begin
                cnt_r <= cnt_r - 8'd1;
            end

            if (capture_s) begin
                out_data_r   <= fpu_data;
                out_status_r <= fpu_status;
            end

            // A clear on the capture edge keeps only the freshly captured status.
            if (clear_sticky) begin
                sticky_r <= capture_s ? fpu_status : 4'd0;
            end else if (capture_s) begin
                sticky_r <= sticky_r | fpu_status;
            end

            if (release_s) begin
                op_count_r <= op_count_r + 8'd1;
            end
        end
    end

    // Outputs decoded from the registered state; the handshake-facing strobes
    // are forced low while reset is held.
    assign bus.in_ready   = reset && (state_r == ST_IDLE);
    assign busy           = reset && (state_r != ST_IDLE);
    assign fpu_reset      = reset && (state_r != ST_START);
    assign bus.out_valid  = (state_r == ST_HOLD);
    assign bus.out_data   = out_data_r;
    assign bus.out_status = out_status_r;
    assign fpu_op_A       = op_a_r;
    assign fpu_op_B       = op_b_r;
    assign sticky_status  = sticky_r;
    assign op_count       = op_count_r;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_sequencer
// Directed self-checking bench for fpu_op_sequencer with LATENCY=8. A small
// fixed-latency FPU stand-in returns table results exactly LATENCY cycles
// after the start pulse is released and garbage at all other times.
// ---------------------------------------------------------------------------
module tb_fpu_op_sequencer;

    localparam int LATENCY = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fpu_op_A;
    logic [31:0] fpu_op_B;
    logic        fpu_reset;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;
    logic [3:0]  sticky_status;
    logic        clear_sticky = 1'b0;
    logic        busy;
    logic [7:0]  op_count;

    int checks   = 0;
    int failures = 0;

    fpu_op_sequencer_if bus ();

    fpu_op_sequencer #(.LATENCY(LATENCY)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .fpu_op_A      (fpu_op_A),
        .fpu_op_B      (fpu_op_B),
        .fpu_reset     (fpu_reset),
        .fpu_data      (fpu_data),
        .fpu_status    (fpu_status),
        .sticky_status (sticky_status),
        .clear_sticky  (clear_sticky),
        .busy          (busy),
        .op_count      (op_count)
    );

    always #5 clock = ~clock;

    // FPU stand-in: operands latched during the start pulse, result valid only
    // on the LATENCY-th cycle after the pulse is released.
    logic [7:0]  fpu_cnt = 8'hFF;
    logic [31:0] lat_a = 32'd0;
    logic [31:0] lat_b = 32'd0;
    logic [3:0]  model_status = 4'd0;

    function automatic logic [31:0] fpu_result(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3E000000_3E000000: return 32'h40000000;
            64'h3F000000_3C000000: return 32'h40000000;
            64'h40000000_40000000: return 32'h42000000;
            64'h3E000000_BE000000: return 32'h00000000;
            default:               return a ^ b;
        endcase
    endfunction

    always @(posedge clock) begin
        if (fpu_reset === 1'b0) begin
            fpu_cnt <= 8'd0;
            lat_a   <= fpu_op_A;
            lat_b   <= fpu_op_B;
        end else if (fpu_cnt != 8'hFF) begin
            fpu_cnt <= fpu_cnt + 8'd1;
        end
    end

    assign fpu_data   = (fpu_cnt == 8'(LATENCY - 1)) ? fpu_result(lat_a, lat_b) : 32'hDEADBEEF;
    assign fpu_status = (fpu_cnt == 8'(LATENCY - 1)) ? model_status : 4'hF;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Present one operand pair, then count edges from accept to out_valid and
    // cycles with fpu_reset low. clr raises clear_sticky for the capture edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] st,
                         input logic clr, output int lat, output int low_cycles);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_op_a  = a;
        bus.in_op_b  = b;
        model_status = st;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat        = 0;
        low_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            if (fpu_reset === 1'b0) low_cycles++;
            if (bus.out_valid === 1'b1) break;
            if (lat == LATENCY) clear_sticky = clr;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        clear_sticky = 1'b0;
    endtask

    task automatic finish_op();
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'd0) begin failures++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data); end
        checks++; if (bus.out_status !== 4'd0) begin failures++; $display("FAIL rst_out_status: got %h expected 0", bus.out_status); end
        checks++; if (sticky_status !== 4'd0) begin failures++; $display("FAIL rst_sticky: got %h expected 0", sticky_status); end
        checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL rst_op_count: got %0d expected 0", op_count); end
        checks++; if ({fpu_op_A, fpu_op_B} !== 64'd0) begin failures++; $display("FAIL rst_fpu_ops: got %h/%h expected 0/0", fpu_op_A, fpu_op_B); end
        checks++; if (fpu_reset !== 1'b0) begin failures++; $display("FAIL rst_fpu_reset: got %b expected 0", fpu_reset); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (fpu_reset !== 1'b1) begin failures++; $display("FAIL rel_fpu_reset: got %b expected 1", fpu_reset); end
    endtask

    task automatic test_basic();
        int lat, low;
        do_op(32'h3E000000, 32'h3E000000, 4'h0, 1'b0, lat, low);
        checks++; if (lat !== 9) begin failures++; $display("FAIL basic_latency: got %0d edges expected 9", lat); end
        checks++; if (low !== 1) begin failures++; $display("FAIL basic_fpu_reset_low: got %0d cycles expected 1", low); end
        checks++; if (bus.out_data !== 32'h40000000) begin failures++; $display("FAIL basic_data: got %h expected 40000000", bus.out_data); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
        finish_op();
        checks++; if (op_count !== 8'd1) begin failures++; $display("FAIL basic_op_count: got %0d expected 1", op_count); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_out_valid_drop: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_idle_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_vectors();
        int lat, low;
        do_op(32'h3F000000, 32'h3C000000, 4'h0, 1'b0, lat, low);
        checks++; if (bus.out_data !== 32'h40000000) begin failures++; $display("FAIL vec1_data: got %h expected 40000000", bus.out_data); end
        finish_op();
        checks++; if (op_count !== 8'd2) begin failures++; $display("FAIL vec1_op_count: got %0d expected 2", op_count); end
        do_op(32'h40000000, 32'h40000000, 4'h0, 1'b0, lat, low);
        checks++; if (bus.out_data !== 32'h42000000) begin failures++; $display("FAIL vec2_data: got %h expected 42000000", bus.out_data); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL vec2_latency: got %0d edges expected 9", lat); end
        finish_op();
        checks++; if (op_count !== 8'd3) begin failures++; $display("FAIL vec2_op_count: got %0d expected 3", op_count); end
    endtask

    task automatic test_backpressure();
        int lat, low;
        do_op(32'h3E000000, 32'hBE000000, 4'h1, 1'b0, lat, low);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            bus.in_valid = (i % 2 == 0);
            bus.in_op_a  = 32'h11111111;
            bus.in_op_b  = 32'h22222222;
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            checks++; if (bus.out_data !== 32'h00000000) begin failures++; $display("FAIL bp_data[%0d]: got %h expected 0", i, bus.out_data); end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            checks++; if ({fpu_op_A, fpu_op_B} !== 64'h3E000000_BE000000) begin failures++; $display("FAIL bp_ops[%0d]: got %h/%h expected 3e000000/be000000", i, fpu_op_A, fpu_op_B); end
        end
        bus.in_valid = 1'b0;
        finish_op();
        checks++; if (op_count !== 8'd4) begin failures++; $display("FAIL bp_op_count: got %0d expected 4", op_count); end
    endtask

    task automatic test_sticky();
        int lat, low;
        checks++; if (sticky_status !== 4'h1) begin failures++; $display("FAIL sticky_accum: got %h expected 1", sticky_status); end
        @(negedge clock);
        clear_sticky = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear_sticky = 1'b0;
        checks++; if (sticky_status !== 4'h0) begin failures++; $display("FAIL sticky_clear: got %h expected 0", sticky_status); end
        do_op(32'h3E000000, 32'h3E000000, 4'b0010, 1'b0, lat, low);
        checks++; if (bus.out_status !== 4'b0010) begin failures++; $display("FAIL sticky_status1: got %h expected 2", bus.out_status); end
        finish_op();
        do_op(32'h3F000000, 32'h3C000000, 4'b1000, 1'b0, lat, low);
        finish_op();
        checks++; if (sticky_status !== 4'b1010) begin failures++; $display("FAIL sticky_or: got %h expected a", sticky_status); end
        do_op(32'h40000000, 32'h40000000, 4'b0100, 1'b1, lat, low);
        checks++; if (sticky_status !== 4'b0100) begin failures++; $display("FAIL sticky_clear_capture: got %h expected 4", sticky_status); end
        finish_op();
        checks++; if (op_count !== 8'd7) begin failures++; $display("FAIL sticky_op_count: got %0d expected 7", op_count); end
    endtask

    task automatic test_reset_mid();
        int lat, low, seen;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_op_a  = 32'h3E000000;
        bus.in_op_b  = 32'h3E000000;
        model_status = 4'h3;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        checks++; if ({bus.in_ready, busy, fpu_reset} !== 3'b000) begin failures++; $display("FAIL mid_strobes: got ready/busy/fpu_reset %b expected 000", {bus.in_ready, busy, fpu_reset}); end
        @(posedge clock);
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if ({bus.out_data, bus.out_status, sticky_status} !== 40'd0) begin failures++; $display("FAIL mid_results: got %h/%h/%h expected 0", bus.out_data, bus.out_status, sticky_status); end
        checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL mid_op_count: got %0d expected 0", op_count); end
        checks++; if ({fpu_op_A, fpu_op_B} !== 64'd0) begin failures++; $display("FAIL mid_fpu_ops: got %h/%h expected 0/0", fpu_op_A, fpu_op_B); end
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after: got %b expected 1", bus.in_ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_capture: got %0d valid cycles expected 0", seen); end
        do_op(32'h40000000, 32'h40000000, 4'h2, 1'b0, lat, low);
        checks++; if (lat !== 9) begin failures++; $display("FAIL mid_next_latency: got %0d edges expected 9", lat); end
        checks++; if (bus.out_data !== 32'h42000000) begin failures++; $display("FAIL mid_next_data: got %h expected 42000000", bus.out_data); end
        finish_op();
        checks++; if (op_count !== 8'd1) begin failures++; $display("FAIL mid_next_count: got %0d expected 1", op_count); end
    endtask

    task automatic test_wrap();
        int lat, low, bad;
        bad = 0;
        for (int i = 0; i < 254; i++) begin
            do_op(32'h3E000000, 32'h3E000000, 4'h0, 1'b0, lat, low);
            if ((bus.out_data !== 32'h40000000) || (lat != 9)) bad++;
            finish_op();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_ops: got %0d bad results expected 0", bad); end
        checks++; if (op_count !== 8'd255) begin failures++; $display("FAIL wrap_255: got %0d expected 255", op_count); end
        do_op(32'h3E000000, 32'h3E000000, 4'h0, 1'b0, lat, low);
        finish_op();
        checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL wrap_zero: got %0d expected 0", op_count); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op_a   = 32'd0;
        bus.in_op_b   = 32'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_sticky();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
